// File: rtl/ddr4_cmd_scheduler.sv
// Open-page DDR4 command scheduler: one request port, 8 banks (2 BG x 4 BA), PRE/ACT/RD/WR
// sequencing with tRCD/tRP/tRAS spacing and periodic precharge-all + auto-refresh.
module ddr4_cmd_scheduler #(
  parameter int T_RCD  = 4,
  parameter int T_RP   = 4,
  parameter int T_RAS  = 10,
  parameter int T_RFC  = 20,
  parameter int T_REFI = 780
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic        req_bg_i,
  input  logic [1:0]  req_ba_i,
  input  logic [16:0] req_row_i,
  input  logic [9:0]  req_col_i,
  output logic        act_n_o,
  output logic        ras_n_a16_o,
  output logic        cas_n_a15_o,
  output logic        we_n_a14_o,
  output logic        bank_group_select_o,
  output logic [1:0]  bank_select_o,
  output logic [16:0] cmd_addr_o,
  output logic        refresh_o,
  output logic        ref_overrun_o
);
  localparam int WW  = $clog2(T_RCD + T_RP + T_RFC + 1);
  localparam int TW  = $clog2(T_RAS + 1);
  localparam int RFW = $clog2(T_REFI + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT,
    S_RW, S_PREA, S_PREA_WAIT, S_REF, S_REF_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [7:0]      open_q, open_d;
  logic [16:0]     row_q [8];
  logic [16:0]     row_d [8];
  logic [TW-1:0]   tras_q [8];
  logic [TW-1:0]   tras_d [8];
  logic [RFW-1:0]  refi_q, refi_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            bg_q, bg_d;
  logic [1:0]      ba_q, ba_d;
  logic [16:0]     addr_q, addr_d;
  logic            ready_q, ready_d;
  logic            refresh_q, refresh_d;

  logic [2:0]      bank_idx;
  logic            row_hit;
  logic            tras_idle;
  logic            refi_expire;

  assign bank_idx    = {req_bg_i, req_ba_i};
  assign row_hit     = open_q[bank_idx] && (row_q[bank_idx] == req_row_i);
  assign refi_expire = (refi_q == RFW'(T_REFI - 1));

  // All-banks tRAS clear, gating precharge-all
  always_comb begin
    tras_idle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tras_idle = tras_idle & (tras_q[i] == '0);
    end
  end

  // Next-state logic; wait counters are loaded with (length - 2) on entry
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          if (open_q == 8'h00)  state_d = S_REF;
          else if (tras_idle)   state_d = S_PREA;
          else                  state_d = S_IDLE;
        end else if (req_valid_i) begin
          if (row_hit)                        state_d = S_RW;
          else if (!open_q[bank_idx])         state_d = S_ACT;
          else if (tras_q[bank_idx] == '0)    state_d = S_PRE;
          else                                state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE:       begin state_d = S_PRE_WAIT;  wait_d = WW'(T_RP - 2);  end
      S_ACT:       begin state_d = S_ACT_WAIT;  wait_d = WW'(T_RCD - 2); end
      S_PREA:      begin state_d = S_PREA_WAIT; wait_d = WW'(T_RP - 2);  end
      S_REF:       begin state_d = S_REF_WAIT;  wait_d = WW'(T_RFC - 2); end
      S_RW:        state_d = S_IDLE;
      S_PRE_WAIT:  if (wait_q == '0) state_d = S_ACT;  else wait_d = wait_q - WW'(1);
      S_ACT_WAIT:  if (wait_q == '0) state_d = S_RW;   else wait_d = wait_q - WW'(1);
      S_PREA_WAIT: if (wait_q == '0) state_d = S_REF;  else wait_d = wait_q - WW'(1);
      S_REF_WAIT:  if (wait_q == '0) state_d = S_IDLE; else wait_d = wait_q - WW'(1);
      default:     state_d = S_IDLE;
    endcase
  end

  // Bank bookkeeping follows the command being registered this edge
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    for (int i = 0; i < 8; i++) begin
      tras_d[i] = (tras_q[i] != '0) ? (tras_q[i] - TW'(1)) : tras_q[i];
    end
    if (state_d == S_ACT) begin
      open_d[bank_idx] = 1'b1;
      row_d[bank_idx]  = req_row_i;
      tras_d[bank_idx] = TW'(T_RAS - 1);
    end else if (state_d == S_PRE) begin
      open_d[bank_idx] = 1'b0;
    end else if ((state_d == S_PREA) || (state_d == S_REF)) begin
      open_d = 8'h00;
    end else begin
      open_d = open_q;
    end
  end

  // Refresh interval timer, pending flag and sticky overrun
  always_comb begin
    refi_d    = refi_expire ? '0 : (refi_q + RFW'(1));
    overrun_d = overrun_q | (refi_expire & pending_q & (state_d != S_REF));
    if (refi_expire)            pending_d = 1'b1;
    else if (state_d == S_REF)  pending_d = 1'b0;
    else                        pending_d = pending_q;
  end

  // Command pins for the state being entered; NOP everywhere else
  always_comb begin
    cmd_d     = 4'b1111;
    bg_d      = 1'b0;
    ba_d      = 2'b00;
    addr_d    = 17'h00000;
    ready_d   = 1'b0;
    refresh_d = 1'b0;
    case (state_d)
      S_ACT: begin
        cmd_d  = {1'b0, req_row_i[16:14]};
        bg_d   = req_bg_i;
        ba_d   = req_ba_i;
        addr_d = req_row_i;
      end
      S_RW: begin
        cmd_d   = {3'b110, ~req_we_i};
        bg_d    = req_bg_i;
        ba_d    = req_ba_i;
        addr_d  = {7'b0000000, req_col_i};
        ready_d = 1'b1;
      end
      S_PRE: begin
        cmd_d = 4'b1010;
        bg_d  = req_bg_i;
        ba_d  = req_ba_i;
      end
      S_PREA: begin
        cmd_d  = 4'b1010;
        addr_d = 17'h00400;
      end
      S_REF: begin
        cmd_d     = 4'b1001;
        refresh_d = 1'b1;
      end
      default: cmd_d = 4'b1111;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      open_q    <= 8'h00;
      refi_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      cmd_q     <= 4'b1111;
      bg_q      <= 1'b0;
      ba_q      <= 2'b00;
      addr_q    <= 17'h00000;
      ready_q   <= 1'b0;
      refresh_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        row_q[i]  <= 17'h00000;
        tras_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      open_q    <= open_d;
      refi_q    <= refi_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      cmd_q     <= cmd_d;
      bg_q      <= bg_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      ready_q   <= ready_d;
      refresh_q <= refresh_d;
      for (int i = 0; i < 8; i++) begin
        row_q[i]  <= row_d[i];
        tras_q[i] <= tras_d[i];
      end
    end
  end

  assign {act_n_o, ras_n_a16_o, cas_n_a15_o, we_n_a14_o} = cmd_q;
  assign bank_group_select_o = bg_q;
  assign bank_select_o       = ba_q;
  assign cmd_addr_o          = addr_q;
  assign req_ready_o         = ready_q;
  assign refresh_o           = refresh_q;
  assign ref_overrun_o       = overrun_q;

  ddr4_cmd_scheduler_chk u_chk (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .req_valid_i (req_valid_i),
    .req_ready_i (ready_q),
    .req_we_i    (req_we_i),
    .req_bg_i    (req_bg_i),
    .req_ba_i    (req_ba_i),
    .req_row_i   (req_row_i),
    .req_col_i   (req_col_i)
  );
endmodule

// Request-port protocol checker: fields must hold while a request waits for req_ready.
module ddr4_cmd_scheduler_chk (
  input logic        clk_i,
  input logic        reset_n_i,
  input logic        req_valid_i,
  input logic        req_ready_i,
  input logic        req_we_i,
  input logic        req_bg_i,
  input logic [1:0]  req_ba_i,
  input logic [16:0] req_row_i,
  input logic [9:0]  req_col_i
);
  a_req_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (req_valid_i && !req_ready_i && $past(req_valid_i) && !$past(req_ready_i))
      |-> $stable({req_we_i, req_bg_i, req_ba_i, req_row_i, req_col_i}));
endmodule
